pio_in_edge_irq: RTL and testbench
==================================

Name: pio_in_edge_irq

Overview:
- Parametrised successor to the team's fixed-width Avalon-MM input PIO slave.
- Synchronises and debounces a WIDTH-bit external input bus (switches, keys) and presents the stable value on a read register.
- Adds per-bit edge capture, an interrupt mask and a level irq output, for attachment to the Nios II system interconnect.

Parameters:
- WIDTH, 10, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flops per bit (>=2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a changed level must persist before acceptance (0 = debounce bypassed).
- EDGE_TYPE, 0, captured edge: 0 rising, 1 falling, 2 both.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  interrupt request, active high, level.

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - Reset is asynchronous and active-low on reset_n.
  - Reset values:
    - All synchroniser flops, stable, debounce counters, irqmask and edgecapture reset to 0.
    - readdata resets to 0; irq resets to 0.
- Synchroniser:
  - in_port passes through a SYNC_STAGES flop chain per bit; its output is synced.
- Debounce, per bit, with counter width clog2(DEBOUNCE_CYCLES+1):
  - synced == stable: counter <= 0.
  - synced != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - synced != stable and counter == DEBOUNCE_CYCLES-1: stable <= synced, counter <= 0.
  - stable therefore changes on the DEBOUNCE_CYCLES-th consecutive differing cycle. Any return to equality restarts the count.
  - DEBOUNCE_CYCLES=0: stable <= synced every cycle.
  - Latency from an in_port change to stable: SYNC_STAGES+DEBOUNCE_CYCLES clocks (6 at defaults). readdata reflects it one clock later.
- Edge capture:
  - edgecapture[i] sets on the same clock that stable[i] toggles in the configured direction.
  - Bits stay set until cleared by software.
  - Inputs held high through reset produce one rising edge after the sync+debounce latency, because stable resets to 0. Software clears edgecapture at init.
- Register map (word addresses):
  - 0: data, read-only; reads {0, stable}; writes ignored.
  - 1: reserved; reads 0; writes ignored.
  - 2: irqmask, R/W, WIDTH bits; upper writedata bits ignored.
  - 3: edgecapture; read returns captured bits. A write clears each bit where writedata[i]=1 (write-1-to-clear).
- Write and read timing:
  - A write occurs when chipselect=1 and write_n=0; the register updates on that clock edge.
  - readdata is re-registered every clock from the address mux, regardless of chipselect. Read latency is 1 clock.
  - Unused upper bits always read 0.
- Simultaneous events:
  - Clear and new edge on the same bit in the same clock: set wins, and the bit remains 1.
  - A write to irqmask and an edge in the same clock both take effect.
- irq:
  - irq = OR over i of (edgecapture[i] & irqmask[i]), registered, so it asserts 1 clock after the capture or mask bit goes high.
  - It deasserts 1 clock after the last contributing bit is cleared or masked.
- Reset mid-operation:
  - Reset asynchronously clears all state, including partially counted debounce.
  - No edge is reported for the reset transition itself.

Test Plan (WIDTH=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated):
1. Reset behaviour:
   - Stimulus: assert reset_n=0 with in_port=0x3FF.
   - Required response: readdata=0 and irq=0 while reset is held.
   - Stimulus: release reset, hold 0x3FF.
   - Required response: address 0 reads 0x3FF starting at clock 7; edgecapture reads 0x3FF.
2. Debounce rejection: from stable 0, pulse bit0 high for 3 clocks then low -> stable, readdata and edgecapture stay 0; a 4-clock pulse is accepted.
3. Edge capture and interrupt:
   - Stimulus: write irqmask=0x001, then raise bit0.
   - Required response: edgecapture=0x001 and irq=1 one clock after capture.
   - Stimulus: write 0x001 to address 3.
   - Required response: edgecapture=0 and irq=0 on the following clock.
4. Mask gating: raise bit5 with irqmask=0x001 -> edgecapture=0x020 and irq stays 0. Then write irqmask=0x021 -> irq=1 one clock later.
5. Set-wins collision: time a write of 0x001 to address 3 on the exact clock bit0's stable rises -> edgecapture[0] remains 1.
6. Edge type and register map:
   - EDGE_TYPE=2: bit3 rises then falls -> each transition sets edgecapture[3], cleared between transitions.
   - Register map: address 1 reads 0; a write to address 0 leaves data unchanged.

Source files
------------

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with synchroniser, per-bit debounce, edge capture and masked level irq.
// Software clears edgecapture at init, because inputs held high through reset report one rising edge.
module pio_in_edge_irq #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      rd_mux;
    logic             wr_en;

    // Synchroniser chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Debounce: a differing level must persist DEBOUNCE_CYCLES consecutive cycles
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_db
            assign stable_nxt = synced;
        end else begin : g_db
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q [WIDTH];
            logic [CNT_W-1:0] cnt_d [WIDTH];

            always_comb begin
                stable_nxt = stable;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = '0;
                    if (synced[i] != stable[i]) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            stable_nxt[i] = synced[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
                end
            end
        end
    endgenerate

    // Edge detection on the stable level
    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = stable_nxt & ~stable;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~stable_nxt & stable;
        end else begin
            edge_det = stable_nxt ^ stable;
        end
    end

    assign wr_en    = chipselect & ~write_n;
    assign clr_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = 32'(stable);
            2'd2:    rd_mux = 32'(irqmask);
            2'd3:    rd_mux = 32'(edgecapture);
            default: rd_mux = '0;
        endcase
    end

    // Register file, read port and irq; a new edge wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable      <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            stable      <= stable_nxt;
            edgecapture <= (edgecapture & ~clr_bits) | edge_det;
            if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
            readdata    <= rd_mux;
            irq         <= |(edgecapture & irqmask);
        end
    end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: directed table, hand sequences and random traffic against a window-based model.
module tb_pio_in_edge_irq;

    localparam int W = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   rd0, rd2;
    logic          irq0, irq2;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_both (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    typedef struct {
        logic [W-1:0] in_v;
        logic [1:0]   addr;
        logic         wr;
        logic [31:0]  wd;
        int           ncyc;
        logic [31:0]  exp_rd;
        logic         exp_irq;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nfail = 0;

    // Reference model: stable takes a level once the last four synchronised samples all show it
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable, m_mask, m_ec0, m_ec2;
    logic [31:0]  m_rd0, m_rd2;
    logic         m_irq0, m_irq2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = {};
        repeat (6) hist.push_back('0);
        m_stable = '0; m_mask = '0; m_ec0 = '0; m_ec2 = '0;
        m_rd0 = '0; m_rd2 = '0; m_irq0 = 1'b0; m_irq2 = 1'b0;
    endtask

    function automatic logic [31:0] reg_view(input logic [1:0] a, input logic [W-1:0] ec);
        case (a)
            2'd0:    return {22'b0, m_stable};
            2'd2:    return {22'b0, m_mask};
            2'd3:    return {22'b0, ec};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [W-1:0] nxt, rise, fall, clr;
        logic         wr;
        int           n;
        hist.push_back(in_port);
        if (hist.size() > 8) void'(hist.pop_front());
        n = hist.size();
        nxt = m_stable;
        for (int b = 0; b < W; b++) begin
            if (hist[n-3][b] != m_stable[b] && hist[n-4][b] == hist[n-3][b] &&
                hist[n-5][b] == hist[n-3][b] && hist[n-6][b] == hist[n-3][b])
                nxt[b] = hist[n-3][b];
        end
        rise = nxt & ~m_stable;
        fall = m_stable & ~nxt;
        wr   = chipselect && !write_n;
        clr  = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        m_rd0  = reg_view(address, m_ec0);
        m_rd2  = reg_view(address, m_ec2);
        m_irq0 = |(m_ec0 & m_mask);
        m_irq2 = |(m_ec2 & m_mask);
        m_ec0  = (m_ec0 & ~clr) | rise;
        m_ec2  = (m_ec2 & ~clr) | rise | fall;
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        m_stable = nxt;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_rd", rd0, m_rd0);
        check("model_irq", {31'b0, irq0}, {31'b0, m_irq0});
        check("model_rd_both", rd2, m_rd2);
        check("model_irq_both", {31'b0, irq2}, {31'b0, m_irq2});
    endtask

    task automatic apply(input vec_t v, input int idx);
        in_port    = v.in_v;
        address    = v.addr;
        chipselect = v.wr;
        write_n    = !v.wr;
        writedata  = v.wd;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (v.ncyc - 1) cycle();
        check($sformatf("tbl%0d_rd", idx), rd0, v.exp_rd);
        check($sformatf("tbl%0d_irq", idx), {31'b0, irq0}, {31'b0, v.exp_irq});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        //          in        addr  wr    wd              n  exp_rd          irq
        tbl.push_back('{10'h000, 2'd0, 1'b0, 32'h0,          8, 32'h000,       1'b0});
        tbl.push_back('{10'h000, 2'd3, 1'b0, 32'h0,          1, 32'h000,       1'b0});
        tbl.push_back('{10'h001, 2'd0, 1'b0, 32'h0,          3, 32'h000,       1'b0});
        tbl.push_back('{10'h000, 2'd0, 1'b0, 32'h0,          8, 32'h000,       1'b0});
        tbl.push_back('{10'h000, 2'd3, 1'b0, 32'h0,          1, 32'h000,       1'b0});
        tbl.push_back('{10'h001, 2'd0, 1'b0, 32'h0,          4, 32'h000,       1'b0});
        tbl.push_back('{10'h000, 2'd0, 1'b0, 32'h0,          3, 32'h001,       1'b0});
        tbl.push_back('{10'h000, 2'd3, 1'b0, 32'h0,          1, 32'h001,       1'b0});
        tbl.push_back('{10'h000, 2'd3, 1'b1, 32'h001,        4, 32'h000,       1'b0});
        tbl.push_back('{10'h000, 2'd0, 1'b0, 32'h0,          1, 32'h000,       1'b0});
        tbl.push_back('{10'h000, 2'd2, 1'b1, 32'hFFFF_FC01,  1, 32'h000,       1'b0});
        tbl.push_back('{10'h000, 2'd2, 1'b0, 32'h0,          1, 32'h001,       1'b0});
        tbl.push_back('{10'h001, 2'd3, 1'b0, 32'h0,          6, 32'h000,       1'b0});
        tbl.push_back('{10'h001, 2'd3, 1'b0, 32'h0,          1, 32'h001,       1'b1});
        tbl.push_back('{10'h001, 2'd3, 1'b1, 32'h001,        1, 32'h001,       1'b1});
        tbl.push_back('{10'h001, 2'd3, 1'b0, 32'h0,          1, 32'h000,       1'b0});
        tbl.push_back('{10'h021, 2'd3, 1'b0, 32'h0,          7, 32'h020,       1'b0});
        tbl.push_back('{10'h021, 2'd2, 1'b1, 32'h021,        1, 32'h001,       1'b0});
        tbl.push_back('{10'h021, 2'd3, 1'b0, 32'h0,          1, 32'h020,       1'b1});
        tbl.push_back('{10'h021, 2'd3, 1'b1, 32'h3FF,        2, 32'h000,       1'b0});
        tbl.push_back('{10'h020, 2'd0, 1'b0, 32'h0,          8, 32'h020,       1'b0});
        tbl.push_back('{10'h021, 2'd3, 1'b0, 32'h0,          5, 32'h000,       1'b0});
        tbl.push_back('{10'h021, 2'd3, 1'b1, 32'h001,        1, 32'h000,       1'b0});
        tbl.push_back('{10'h021, 2'd3, 1'b0, 32'h0,          1, 32'h001,       1'b1});
        tbl.push_back('{10'h021, 2'd1, 1'b1, 32'hFFFF_FFFF,  1, 32'h000,       1'b1});
        tbl.push_back('{10'h021, 2'd0, 1'b1, 32'h0,          2, 32'h021,       1'b1});

        // Reset held with all inputs high
        in_port = 10'h3FF;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("rst_rd", rd0, 32'h0);
            check("rst_irq", {31'b0, irq0}, 32'h0);
            check("rst_rd_both", rd2, 32'h0);
        end
        reset_n = 1'b1;
        repeat (6) cycle();
        check("init_rd_clk6", rd0, 32'h0);
        cycle();
        check("init_rd_clk7", rd0, 32'h3FF);
        address = 2'd3;
        cycle();
        check("init_ec", rd0, 32'h3FF);
        check("init_ec_both", rd2, 32'h3FF);
        bus_write(2'd3, 32'h3FF);
        cycle();
        check("init_ec_clr", rd0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Both-edge capture on bit3, cleared between transitions
        in_port = 10'h029;
        bus_write(2'd3, 32'h3FF);
        repeat (6) cycle();
        check("both_rise_rd", rd2, 32'h008);
        check("rise_rd", rd0, 32'h008);
        bus_write(2'd3, 32'h008);
        cycle();
        check("both_clr_rd", rd2, 32'h000);
        in_port = 10'h021;
        repeat (7) cycle();
        check("both_fall_rd", rd2, 32'h008);
        check("rise_only_fall_rd", rd0, 32'h000);

        // Asynchronous reset during a partial debounce count
        address = 2'd0;
        in_port = 10'h3DE;
        repeat (3) cycle();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_rd", rd0, 32'h0);
        check("async_rst_irq", {31'b0, irq0}, 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) cycle();
        check("post_rst_clk6", rd0, 32'h0);
        cycle();
        check("post_rst_clk7", rd0, 32'h3DE);

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) in_port = in_port ^ W'($urandom & $urandom);
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            cycle();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
